score_sequencer: RTL
====================

Name: score_sequencer

Overview:
- Sequences all score updates into the 4-digit BCD score accumulator. That accumulator adds a per-digit add vector on every clock.
- Shares the accumulator between NUM_SRC requesters (e.g. line-clear, soft-drop, level bonus) using valid/ready handshakes and round-robin arbitration.
- Replays each granted amount a requested number of times, so the level multiplier becomes repeated addition.
- Keeps add_digits at zero between pulses so the accumulator only ever sees single-cycle adds.

Parameters:
- NUM_SRC, 3, number of requesters (2..8).
- REP_W, 4, width of the per-request repeat count.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_SRC  request pending, one bit per source.
- req_ready  out  NUM_SRC  one-hot accept strobe.
- req_amount  in  NUM_SRC x 4 x 5  per-source BCD amount; digit 0 is the units digit.
- req_repeat  in  NUM_SRC x REP_W  number of times the amount is added.
- score_digits  in  4 x 5  current accumulator value, fed back from the accumulator output.
- add_digits  out  4 x 5  add vector driven into the accumulator.
- busy  out  1  high in any state other than IDLE.
- done  out  1  single-cycle pulse when a request completes.
- done_src  out  clog2(NUM_SRC)  index of the completed source; valid while done=1.

Behaviour:
- Reset values: add_digits=0, req_ready=0, busy=0, done=0, done_src=0, state=IDLE, remaining=0, rr_last=NUM_SRC-1 (source 0 wins first).
- Reset mid-operation aborts the request. No further add pulses are issued. Partial adds already applied stay in the accumulator.
- FSM states: IDLE, ADD, SETTLE, DONE.
- IDLE, arbitration:
  - Round-robin search starts at rr_last+1 and wraps modulo NUM_SRC.
  - req_ready[g] is asserted combinationally for the winner g while the FSM is in IDLE and req_valid[g]=1.
  - On that edge the block latches amount, repeat and g.
  - Next state is ADD if repeat>0. If repeat==0 it is DONE, and no add is issued.
- Requester rule: a source holds req_valid, req_amount and req_repeat stable until it sees req_ready. Deasserting valid before ready is legal; the request is simply dropped.
- ADD: add_digits = latched amount for exactly one cycle. remaining decrements. Next state is SETTLE.
- SETTLE: add_digits=0 for one cycle so score_digits reflects the previous add. Next state is ADD if remaining>0, else DONE.
- DONE: done=1, done_src=g, rr_last=g. Next state is IDLE. New requests are not accepted in DONE.
- Latency: a request with repeat R>0 takes 2R+2 cycles from accept edge to return to IDLE. The first add_digits pulse appears the cycle after accept.
- Arithmetic:
  - Any latched amount digit >9 is clamped to 9 at latch time.
  - remaining is REP_W bits, so the maximum is 2^REP_W-1 repeats.
  - No carries are generated here; BCD carry handling stays in the accumulator.
- Simultaneous requests: only one grant per IDLE cycle. Losers keep valid asserted and are served in later rounds. All valid sources are served before any source repeats.
- Without SCORE_SAT_EN, accumulator wrap past 9999 is the accumulator's behaviour and is not prevented here.

Optional Feature:
- Macro: SCORE_SAT_EN.
- Defined: in ADD, compute the decimal value of score_digits and of the amount (digit weights 1/10/100/1000).
  - If their sum exceeds 9999, drive add_digits[i] = 9 - score_digits[i] instead of the amount. The accumulator then reaches exactly 9999 with no carries.
  - Clear remaining and go to SETTLE, then DONE.
  - If score_digits already equals 9999, drive zero.
- Undefined: amounts pass unmodified and score_digits is ignored (port kept, unused).

Decomposition:
- Package score_pkg holds:
  - typedef bcd_digit_t (logic [4:0]);
  - typedef bcd_score_t (bcd_digit_t [4]);
  - SCORE_DIGITS=4, BCD_MAX=9, SCORE_MAX=9999;
  - the FSM state enum seq_state_t.
- Sub-module rr_arbiter: parameterised by NUM_SRC. Inputs req and last-grant pointer; outputs one-hot grant plus encoded index. Purely combinational, reusable elsewhere.

Test Plan:
- Reset then single request: src1 amount 0040, repeat 3 -> ready[1] for 1 cycle, add_digits=0040 on 3 cycles with zero between, done with done_src=1 at cycle 8, accumulator 0120.
- All three sources valid simultaneously with repeat 1 -> grants in order 0,1,2, then 0 again only if still valid. No two readies in the same cycle.
- repeat=0 from src2 -> ready, no add_digits pulse, done after 2 cycles, accumulator unchanged.
- Amount digit 12 in units position, repeat 1 -> add_digits[0]=9.
- Reset asserted during SETTLE of a repeat-5 request -> add_digits 0 next cycle, busy 0, no done, src0 wins next arbitration.
- SCORE_SAT_EN defined, score 9950, amount 1200 repeat 2 -> single add 0049, accumulator 9999, done after one pulse. Undefined -> accumulator wraps to 2350 (mod 10000).

Source files
------------

// File: rtl/score_pkg.sv
// score_pkg: shared types, constants and helpers for the score sequencer.
//   bcd_digit_t  - one BCD digit held in 5 bits (values above 9 are possible on input)
//   bcd_score_t  - four packed digits, digit 0 is the units digit
//   seq_state_t  - sequencer FSM states
package score_pkg;

   localparam int unsigned SCORE_DIGITS = 4;
   localparam int unsigned SCORE_MAX    = 9999;

   typedef logic [4:0] bcd_digit_t;
   typedef bcd_digit_t [SCORE_DIGITS-1:0] bcd_score_t;

   localparam bcd_digit_t BCD_MAX = 5'd9;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      SETTLE,
      DONE
   } seq_state_t;

   // Limit every digit to 9 so the accumulator never sees an illegal BCD digit.
   function automatic bcd_score_t clamp_score(input bcd_score_t s);
      bcd_score_t r;
      r = '0;
      for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
         r[i] = (s[i] > BCD_MAX) ? BCD_MAX : s[i];
      end
      return r;
   endfunction

   function automatic int unsigned bcd_to_int(input bcd_score_t s);
      int unsigned v;
      int unsigned w;
      v = 0;
      w = 1;
      for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
         v = v + 32'(s[i]) * w;
         w = w * 10;
      end
      return v;
   endfunction

   function automatic logic sat_exceeds(input bcd_score_t amount, input bcd_score_t score);
      return (bcd_to_int(amount) + bcd_to_int(score)) > SCORE_MAX;
   endfunction

   // Per-digit distance to 9: adding this brings the score to exactly 9999 with no carries.
   function automatic bcd_score_t headroom(input bcd_score_t score);
      bcd_score_t r;
      r = '0;
      for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
         r[i] = (score[i] > BCD_MAX) ? '0 : BCD_MAX - score[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/score_sequencer_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req       - request vector, one bit per source
//   last      - index of the most recently served source; search starts at last+1
//   grant     - one-hot winner (zero when no request)
//   grant_idx - encoded winner index
//   any       - at least one request is pending
module rr_arbiter #(
   parameter int unsigned NUM_SRC = 3
) (
   input  logic [NUM_SRC-1:0]         req,
   input  logic [$clog2(NUM_SRC)-1:0] last,
   output logic [NUM_SRC-1:0]         grant,
   output logic [$clog2(NUM_SRC)-1:0] grant_idx,
   output logic                       any
);

   localparam int unsigned IDX_W = $clog2(NUM_SRC);

   function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
      return IDX_W'(v % NUM_SRC);
   endfunction

   // Offsets 1..NUM_SRC visit every source once, ending on last itself.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int unsigned i = 1; i <= NUM_SRC; i++) begin
         if (!any && req[wrap_idx(32'(last) + i)]) begin
            any                             = 1'b1;
            grant[wrap_idx(32'(last) + i)]  = 1'b1;
            grant_idx                       = wrap_idx(32'(last) + i);
         end
      end
   end

endmodule

// File: rtl/score_sequencer.sv
// score_sequencer: arbitrates score update requests and replays each granted
// amount into the BCD score accumulator as single-cycle add pulses separated
// by a zero cycle.
//   clk, reset    - clock, synchronous active-high reset
//   req_valid     - per-source request pending
//   req_ready     - one-hot accept strobe (combinational, IDLE only)
//   req_amount    - per-source BCD amount, digit 0 = units
//   req_repeat    - per-source number of times the amount is added
//   score_digits  - accumulator value fed back (used only with SCORE_SAT_EN)
//   add_digits    - add vector to the accumulator
//   busy          - high whenever the FSM is not in IDLE
//   done/done_src - single-cycle completion pulse and source index
// Build option: define SCORE_SAT_EN to stop the score at 9999 instead of wrapping.
module score_sequencer
   import score_pkg::*;
#(
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned REP_W   = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_SRC-1:0]                req_valid,
   output logic [NUM_SRC-1:0]                req_ready,
   input  bcd_score_t [NUM_SRC-1:0]          req_amount,
   input  logic [NUM_SRC-1:0][REP_W-1:0]     req_repeat,
   input  bcd_score_t                        score_digits,
   output bcd_score_t                        add_digits,
   output logic                              busy,
   output logic                              done,
   output logic [$clog2(NUM_SRC)-1:0]        done_src
);

   localparam int unsigned IDX_W = $clog2(NUM_SRC);

   seq_state_t       state;
   logic [REP_W-1:0] remaining;
   logic [IDX_W-1:0] rr_last;
   logic [IDX_W-1:0] src;
   bcd_score_t       amount;
   logic             sat_hit;

   logic [NUM_SRC-1:0] grant;
   logic [IDX_W-1:0]   gidx;
   logic               any_req;

   bcd_score_t       amt_in;
   logic [REP_W-1:0] rep_in;
   bcd_score_t       pulse_base;
   bcd_score_t       pulse;
   logic             pulse_sat;

   rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
      .req       (req_valid),
      .last      (rr_last),
      .grant     (grant),
      .grant_idx (gidx),
      .any       (any_req)
   );

   always_comb begin
      req_ready = '0;
      if (state == IDLE && !reset) begin
         req_ready = grant;
      end
   end

   always_comb begin
      amt_in     = clamp_score(req_amount[gidx]);
      rep_in     = req_repeat[gidx];
      pulse_base = (state == IDLE) ? amt_in : amount;
   end

   // add_digits is registered, so the pulse for the coming ADD cycle is formed
   // on the edge entering ADD. The accumulator is idle in IDLE/SETTLE, so the
   // score seen here is the score present during ADD.
`ifdef SCORE_SAT_EN
   always_comb begin
      pulse_sat = sat_exceeds(pulse_base, score_digits);
      pulse     = pulse_sat ? headroom(score_digits) : pulse_base;
   end
`else
   logic score_unused;
   assign score_unused = ^score_digits;

   always_comb begin
      pulse_sat = 1'b0;
      pulse     = pulse_base;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         add_digits <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         done_src   <= '0;
         remaining  <= '0;
         rr_last    <= IDX_W'(NUM_SRC - 1);
         src        <= '0;
         amount     <= '0;
         sat_hit    <= 1'b0;
      end else begin
         add_digits <= '0;
         done       <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  amount <= amt_in;
                  src    <= gidx;
                  busy   <= 1'b1;
                  if (rep_in != '0) begin
                     remaining  <= rep_in;
                     add_digits <= pulse;
                     sat_hit    <= pulse_sat;
                     state      <= ADD;
                  end else begin
                     done     <= 1'b1;
                     done_src <= gidx;
                     state    <= DONE;
                  end
               end
            end
            ADD: begin
               remaining <= sat_hit ? '0 : remaining - REP_W'(1);
               state     <= SETTLE;
            end
            SETTLE: begin
               if (remaining != '0) begin
                  add_digits <= pulse;
                  sat_hit    <= pulse_sat;
                  state      <= ADD;
               end else begin
                  done     <= 1'b1;
                  done_src <= src;
                  state    <= DONE;
               end
            end
            DONE: begin
               rr_last <= src;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
